// File: rtl/alu_chk_pkg.sv
// Shared types, opcodes and the golden arithmetic model for the ALU response checker.
package alu_chk_pkg;
   localparam int CHK_N = 2;
   localparam int CHK_M = 4;

   localparam logic [CHK_N-1:0] OP_SUB = 2'b00;
   localparam logic [CHK_N-1:0] OP_ADD = 2'b01;
   localparam logic [CHK_N-1:0] OP_AND = 2'b10;
   localparam logic [CHK_N-1:0] OP_NEG = 2'b11;

   localparam int ST_N = 3;
   localparam int ST_Z = 2;
   localparam int ST_V = 1;
   localparam int ST_C = 0;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2,
      DONE  = 2'd3
   } chk_state_e;

   // Returns {res, status}; bit CHK_M of the widened result is carry (add) or borrow (sub/neg)
   function automatic logic [CHK_M+3:0] alu_ref_f(input logic [CHK_N-1:0] op,
                                                  input logic [CHK_M-1:0] a,
                                                  input logic [CHK_M-1:0] b);
      logic [CHK_M:0]   w_ext;
      logic [CHK_M-1:0] w_res;
      logic [3:0]       w_st;
      w_ext = '0;
      w_st  = 4'b0000;
      case (op)
         OP_SUB: begin
            w_ext       = {1'b0, a} - {1'b0, b};
            w_st[ST_V]  = (a[CHK_M-1] != b[CHK_M-1]) && (w_ext[CHK_M-1] != a[CHK_M-1]);
            w_st[ST_C]  = w_ext[CHK_M];
         end
         OP_ADD: begin
            w_ext       = {1'b0, a} + {1'b0, b};
            w_st[ST_V]  = (a[CHK_M-1] == b[CHK_M-1]) && (w_ext[CHK_M-1] != a[CHK_M-1]);
            w_st[ST_C]  = w_ext[CHK_M];
         end
         OP_AND: begin
            w_ext       = {1'b0, a & b};
         end
         OP_NEG: begin
            w_ext       = {(CHK_M+1){1'b0}} - {1'b0, a};
            w_st[ST_V]  = a[CHK_M-1] && w_ext[CHK_M-1];
            w_st[ST_C]  = w_ext[CHK_M];
         end
         default: begin
            w_ext       = '0;
         end
      endcase
      w_res      = w_ext[CHK_M-1:0];
      w_st[ST_N] = w_res[CHK_M-1];
      w_st[ST_Z] = (w_res == {CHK_M{1'b0}});
      return {w_res, w_st};
   endfunction
endpackage

// File: rtl/alu_result_checker_delay.sv
// K-deep valid+payload shift register aligning issued vectors with the DUT's delayed response.
module chk_delay_line #(
   parameter int W = 10,
   parameter int K = 1
) (
   input  logic         i_clk,
   input  logic         i_reset,
   input  logic         i_clear,
   input  logic         i_valid,
   input  logic [W-1:0] i_data,
   output logic         o_valid,
   output logic [W-1:0] o_data
);
   logic [K-1:0] r_vld;
   logic [W-1:0] r_data [K];

   // Stage 0 takes the newly issued vector; every stage advances one place per cycle
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_vld <= '0;
         for (int i = 0; i < K; i++) r_data[i] <= '0;
      end else if (i_clear) begin
         r_vld <= '0;
      end else begin
         r_vld[0]  <= i_valid;
         r_data[0] <= i_data;
         for (int i = 1; i < K; i++) begin
            r_vld[i]  <= r_vld[i-1];
            r_data[i] <= r_data[i-1];
         end
      end
   end

   assign o_valid = r_vld[K-1];
   assign o_data  = r_data[K-1];
endmodule

// File: rtl/alu_result_checker.sv
// Response checker for sync_arith_unit_4: aligns stimulus with DUT output, compares against
// the reference model, counts passes/fails and latches the first failing vector.
module alu_result_checker
   import alu_chk_pkg::*;
#(
   parameter int N     = CHK_N,
   parameter int M     = CHK_M,
   parameter int K     = 1,
   parameter int CNT_W = 16
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_start,
   input  logic             i_stop,
   input  logic             i_valid,
   input  logic [N-1:0]     i_op,
   input  logic [M-1:0]     i_arg_A,
   input  logic [M-1:0]     i_arg_B,
   input  logic [M-1:0]     i_dut_result,
   input  logic [3:0]       i_dut_status,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_mismatch,
   output logic             o_err,
   output logic [CNT_W-1:0] o_pass_cnt,
   output logic [CNT_W-1:0] o_fail_cnt,
   output logic [N+2*M-1:0] o_first_fail
);
   localparam int W = N + 2*M;

   chk_state_e       r_state;
   logic [3:0]       r_flush_cnt;
   logic             r_busy, r_done, r_mismatch, r_err;
   logic [CNT_W-1:0] r_pass_cnt, r_fail_cnt;
   logic [W-1:0]     r_first_fail;

   logic             w_start_acc, w_capture, w_cmp_vld, w_cmp_en, w_cmp_fail;
   logic [W-1:0]     w_cmp_vec;
   logic [M+3:0]     w_exp;

   // A start is honoured only from IDLE/DONE, so it also beats a simultaneous stop
   assign w_start_acc = i_start && ((r_state == IDLE) || (r_state == DONE));
   assign w_capture   = i_valid && (r_state == RUN);

   chk_delay_line #(.W(W), .K(K)) u_delay (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_clear (w_start_acc),
      .i_valid (w_capture),
      .i_data  ({i_op, i_arg_A, i_arg_B}),
      .o_valid (w_cmp_vld),
      .o_data  (w_cmp_vec)
   );

   assign w_exp      = alu_ref_f(w_cmp_vec[W-1 -: N], w_cmp_vec[2*M-1 -: M], w_cmp_vec[M-1:0]);
   assign w_cmp_en   = w_cmp_vld && ((r_state == RUN) || (r_state == FLUSH));
   assign w_cmp_fail = (w_exp != {i_dut_result, i_dut_status});

   // Run-control FSM; FLUSH lasts exactly K cycles so the last captured vector still gets compared
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state     <= IDLE;
         r_flush_cnt <= 4'd0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         case (r_state)
            IDLE, DONE: begin
               if (i_start) begin
                  r_state <= RUN;
                  r_busy  <= 1'b1;
                  r_done  <= 1'b0;
               end
            end
            RUN: begin
               if (i_stop) begin
                  r_state     <= FLUSH;
                  r_flush_cnt <= 4'd0;
               end
            end
            FLUSH: begin
               if (r_flush_cnt == 4'(K-1)) begin
                  r_state <= DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end else begin
                  r_flush_cnt <= r_flush_cnt + 4'd1;
               end
            end
            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   // Compare bookkeeping: saturating counters, one-cycle mismatch pulse, first-fail latch
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_mismatch   <= 1'b0;
         r_err        <= 1'b0;
         r_pass_cnt   <= '0;
         r_fail_cnt   <= '0;
         r_first_fail <= '0;
      end else if (w_start_acc) begin
         r_mismatch   <= 1'b0;
         r_err        <= 1'b0;
         r_pass_cnt   <= '0;
         r_fail_cnt   <= '0;
         r_first_fail <= '0;
      end else begin
         r_mismatch <= 1'b0;
         if (w_cmp_en && w_cmp_fail) begin
            r_mismatch <= 1'b1;
            if (r_fail_cnt != {CNT_W{1'b1}}) r_fail_cnt <= r_fail_cnt + CNT_W'(1);
            if (!r_err) begin
               r_err        <= 1'b1;
               r_first_fail <= w_cmp_vec;
            end
         end else if (w_cmp_en) begin
            if (r_pass_cnt != {CNT_W{1'b1}}) r_pass_cnt <= r_pass_cnt + CNT_W'(1);
         end
      end
   end

   assign o_busy       = r_busy;
   assign o_done       = r_done;
   assign o_mismatch   = r_mismatch;
   assign o_err        = r_err;
   assign o_pass_cnt   = r_pass_cnt;
   assign o_fail_cnt   = r_fail_cnt;
   assign o_first_fail = r_first_fail;
endmodule
